// File: rtl/unibus_arbiter.sv
// unibus_arbiter: round-robin arbiter granting four sources onto a registered 4-bit bus,
// with a per-transfer ready timeout.
module unibus_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] data0,
    input  logic [3:0] data1,
    input  logic [3:0] data2,
    input  logic [3:0] data3,
    input  logic       bus_ready,
    output logic [3:0] grant,
    output logic [3:0] bus_data,
    output logic       bus_valid,
    output logic       done,
    output logic       timeout_err
);
    typedef enum logic {IDLE, XFER} state_t;
    localparam logic [3:0] LP_TMAX = 4'(TIMEOUT - 1);
    state_t     r_state;
    logic [1:0] r_ptr;
    logic [1:0] r_win;
    logic [3:0] r_cnt;
    logic [1:0] w_win;
    logic [3:0] w_data;
    // Scan from ptr+3 down to ptr so the closest requester after ptr wins.
    always_comb begin
        w_win = r_ptr;
        for (int k = 3; k >= 0; k--)
            if (req[r_ptr + 2'(k)]) w_win = r_ptr + 2'(k);
        w_data = (w_win == 2'd0) ? data0 :
                 (w_win == 2'd1) ? data1 :
                 (w_win == 2'd2) ? data2 : data3;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_win       <= '0;
            r_cnt       <= '0;
            grant       <= '0;
            bus_data    <= '0;
            bus_valid   <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            done        <= 1'b0;
            timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req != 4'd0) begin
                        bus_data  <= w_data;
                        grant     <= 4'b0001 << w_win;
                        bus_valid <= 1'b1;
                        r_win     <= w_win;
                        r_cnt     <= '0;
                        r_state   <= XFER;
                    end
                end
                XFER: begin
                    // Ready on the final wait cycle still counts as success.
                    if (bus_ready || r_cnt == LP_TMAX) begin
                        grant       <= '0;
                        bus_valid   <= 1'b0;
                        done        <= bus_ready;
                        timeout_err <= !bus_ready;
                        r_ptr       <= r_win + 2'd1;
                        r_state     <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_unibus_arbiter.sv
// tb_unibus_arbiter: scoreboard bench; a behavioural model pushes expected outputs
// per driven cycle, which are popped and compared after the clock edge.
module tb_unibus_arbiter;
    localparam int TO = 15;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] data0 = '0, data1 = '0, data2 = '0, data3 = '0;
    logic       bus_ready = 1'b0;
    logic [3:0] grant, bus_data;
    logic       bus_valid, done, timeout_err;
    int n_tot = 0;
    int n_bad = 0;
    logic [10:0] sb_q[$];
    int         m_state, m_ptr, m_cnt, m_win;
    logic [3:0] m_grant, m_data;
    logic       m_valid, m_done, m_terr;

    unibus_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .data0(data0), .data1(data1), .data2(data2), .data3(data3),
        .bus_ready(bus_ready), .grant(grant), .bus_data(bus_data),
        .bus_valid(bus_valid), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] outs();
        return {grant, bus_data, bus_valid, done, timeout_err};
    endfunction

    task automatic model_reset();
        m_state = 0; m_ptr = 0; m_cnt = 0; m_win = 0;
        m_grant = '0; m_data = '0; m_valid = 0; m_done = 0; m_terr = 0;
    endtask

    task automatic model_step();
        logic [3:0] d[4];
        d[0] = data0; d[1] = data1; d[2] = data2; d[3] = data3;
        m_done = 0;
        m_terr = 0;
        if (m_state == 0) begin
            if (req != 0) begin
                for (int k = 0; k < 4; k++)
                    if (req[(m_ptr + k) % 4]) begin
                        m_win = (m_ptr + k) % 4;
                        break;
                    end
                m_grant = 4'(1 << m_win);
                m_data = d[m_win];
                m_valid = 1;
                m_cnt = 0;
                m_state = 1;
            end
        end else if (bus_ready) begin
            m_done = 1; m_grant = 0; m_valid = 0; m_ptr = (m_win + 1) % 4; m_state = 0;
        end else if (m_cnt == TO - 1) begin
            m_terr = 1; m_grant = 0; m_valid = 0; m_ptr = (m_win + 1) % 4; m_state = 0;
        end else begin
            m_cnt++;
        end
    endtask

    // Drive one cycle, predict, clock, compare.
    task automatic step(input string tag, input logic [3:0] r, input logic [15:0] d, input logic rdy);
        req = r; {data3, data2, data1, data0} = d; bus_ready = rdy;
        model_step();
        sb_q.push_back({m_grant, m_data, m_valid, m_done, m_terr});
        @(posedge clk);
        #1;
        chk(tag, outs(), sb_q.pop_front());
        chk("excl", {31'd0, done & timeout_err}, 32'd0);
    endtask

    initial begin
        model_reset();
        #1;
        chk("rst_async", outs(), 11'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Single request from source 2, then ptr should sit at 3.
        step("single", 4'b0100, 16'h0A00, 1'b1);
        chk("single_grant", {grant, bus_data, bus_valid}, {4'b0100, 4'hA, 1'b1});
        step("single_done", 4'b0000, 16'h0000, 1'b1);
        chk("single_done_p", {done, grant}, {1'b1, 4'b0000});
        step("ptr3", 4'b1111, 16'h4321, 1'b1);
        chk("ptr3_grant", grant, 4'b1000);
        step("ptr3_done", 4'b1111, 16'h4321, 1'b1);
        // Round-robin with all requesters held.
        for (int i = 0; i < 10; i++) step("rr", 4'b1111, 16'h4321, 1'b1);
        // Stall three cycles with data churn, then accept.
        step("stall_g", 4'b0001, 16'h0005, 1'b0);
        for (int i = 0; i < 3; i++) step("stall", 4'(i + 2), 16'(16'hFFF0 + i), 1'b0);
        chk("stall_data", bus_data, 4'h5);
        step("stall_done", 4'b0000, 16'h1234, 1'b1);
        chk("stall_done_p", done, 1'b1);
        // Timeout on source 1, then source 2 is next in line.
        step("to_g", 4'b0010, 16'h00C0, 1'b0);
        for (int i = 0; i < TO; i++) step("to_wait", 4'b0000, 16'h0000, 1'b0);
        chk("to_pulse", {timeout_err, done, bus_valid}, 3'b100);
        step("to_next", 4'b1111, 16'h9876, 1'b0);
        chk("to_next_g", grant, 4'b0100);
        // Boundary: ready arrives on the last permitted wait cycle.
        for (int i = 0; i < TO - 1; i++) step("bd_wait", 4'b0000, 16'h0000, 1'b0);
        step("bd_last", 4'b0000, 16'h0000, 1'b1);
        chk("bd_pulse", {done, timeout_err}, 2'b10);
        // Randomised traffic.
        for (int i = 0; i < 300; i++)
            step("rand", 4'($urandom_range(0, 15)), 16'($urandom), ($urandom_range(0, 3) != 0));
        // Reset mid-transfer.
        step("mr_g", 4'b0010, 16'h00E0, 1'b0);
        chk("mr_valid", bus_valid, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_async", outs(), 11'd0);
        model_reset();
        @(posedge clk);
        #1;
        chk("mr_hold", outs(), 11'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("mr_wrap", 4'b1000, 16'hB000, 1'b0);
        chk("mr_wrap_g", grant, 4'b1000);
        step("mr_end", 4'b0000, 16'h0000, 1'b1);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
